// File: rtl/switch_debounce.sv
// switch_debounce: 8-bit switch synchronizer and debouncer with one-cycle change pulse and mask.
// Optional sticky interrupt output enabled by defining SWITCH_DEBOUNCE_IRQ_EN.
module switch_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iSwitch,
  output logic [7:0] oSwitch,
  output logic       oChanged,
  output logic [7:0] oChangedMask
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  ,
  input  logic       iIrqClr,
  output logic       oIrq
`endif
);
  typedef enum logic {STABLE, SETTLE} stateE;
  stateE state, stateNext;
  logic [7:0] sync1, sync2, cand, candNext;
  logic [19:0] cnt, cntNext;
  logic commit;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= STABLE;
      cand <= '0;
      cnt <= '0;
      oSwitch <= '0;
      oChanged <= 1'b0;
      oChangedMask <= '0;
    end else begin
      sync1 <= iSwitch;
      sync2 <= sync1;
      state <= stateNext;
      cand <= candNext;
      cnt <= cntNext;
      oChanged <= commit;
      oChangedMask <= commit ? cand ^ oSwitch : '0;
      if (commit) oSwitch <= cand;
    end
  always_comb
    stateNext = (state == STABLE) ? ((sync2 != oSwitch) ? SETTLE : STABLE)
                                  : ((sync2 == oSwitch || commit) ? STABLE : SETTLE);
  // Counter is compared before incrementing, so it saturates at DEBOUNCE_CYCLES.
  always_comb begin
    candNext = cand;
    cntNext = cnt;
    commit = 1'b0;
    if (state == STABLE) begin
      cntNext = (sync2 != oSwitch) ? 20'd1 : '0;
      candNext = (sync2 != oSwitch) ? sync2 : cand;
    end else if (sync2 == oSwitch) begin
      cntNext = '0;
    end else if (sync2 != cand) begin
      candNext = sync2;
      cntNext = 20'd1;
    end else if (cnt < DEBOUNCE_CYCLES) begin
      cntNext = cnt + 20'd1;
    end else begin
      commit = 1'b1;
      cntNext = '0;
    end
  end
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  // Set has priority over clear.
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) oIrq <= 1'b0;
    else oIrq <= oChanged ? 1'b1 : (iIrqClr ? 1'b0 : oIrq);
`endif
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 20'd50000, meaning consecutive stable cycles required before committing; legal range 1..1048575.
REQ-002 The module SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port iRst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port iSwitch, input, 8 bits: raw, asynchronous board switch levels.
REQ-005 The module SHALL have port oSwitch, output, 8 bits: debounced switch levels, registered, feeding the data-memory switch input.
REQ-006 The module SHALL have port oChanged, output, 1 bit: one-cycle pulse when oSwitch takes a new value.
REQ-007 The module SHALL have port oChangedMask, output, 8 bits: the XOR of the new and previous oSwitch, valid only while oChanged=1, otherwise 0.

Function
REQ-008 iSwitch SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-009 The controller SHALL have two states: STABLE and SETTLE, plus an 8-bit candidate register and a 20-bit counter.
REQ-010 In STABLE with sync2 == oSwitch, the state SHALL hold, the counter SHALL be 0, and oChanged SHALL be 0.
REQ-011 In STABLE with sync2 != oSwitch, the next state SHALL be SETTLE, with candidate <= sync2 and counter <= 1.
REQ-012 In SETTLE with sync2 == oSwitch, the next state SHALL be STABLE with counter <= 0, and no commit SHALL occur (glitch rejected).
REQ-013 In SETTLE with sync2 differing from both candidate and oSwitch, the block SHALL set candidate <= sync2 and counter <= 1, and SHALL stay in SETTLE.
REQ-014 In SETTLE with sync2 == candidate and counter < DEBOUNCE_CYCLES, the counter SHALL increment.
REQ-015 In SETTLE with sync2 == candidate and counter == DEBOUNCE_CYCLES, the block SHALL set oSwitch <= candidate, oChanged <= 1, oChangedMask <= candidate ^ oSwitch, and next state STABLE.
REQ-016 Latency SHALL be as follows: a clean iSwitch change first sampled at rising edge 1 SHALL appear on oSwitch after edge DEBOUNCE_CYCLES+3.
REQ-017 oChanged SHALL be high for exactly one cycle per commit, and consecutive commits SHALL be separated by at least DEBOUNCE_CYCLES+1 cycles.
REQ-018 Multiple bits changing together or staggered inside the settle window SHALL commit as one update with a combined mask.
REQ-019 The counter SHALL never wrap, and SHALL saturate at DEBOUNCE_CYCLES because it is compared before incrementing.

Reset
REQ-020 While iRst=1, the following SHALL be forced immediately and independently of iClk: sync1, sync2, candidate, oSwitch, and oChangedMask to 8'h00; counter to 0; oChanged to 0; state to STABLE.
REQ-021 Reset asserted mid-SETTLE SHALL discard the candidate, and no oChanged pulse SHALL follow deassertion unless the settle sequence restarts and completes.
REQ-022 After deassertion with iSwitch nonzero, the first commit SHALL occur at the normal REQ-016 latency and SHALL report the full nonzero mask.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_IRQ_EN SHALL control an interrupt feature, as specified in REQ-024 and REQ-025.
REQ-024 When SWITCH_DEBOUNCE_IRQ_EN is defined, the module SHALL add the following ports and behaviour:
- input iIrqClr, 1 bit
- output oIrq, 1 bit, sticky, reset 0
- oIrq set on the cycle after any oChanged=1
- oIrq cleared on the cycle after iIrqClr=1
- set wins when set and clear coincide
REQ-025 When SWITCH_DEBOUNCE_IRQ_EN is undefined, iIrqClr and oIrq SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 The bench SHALL cover the following scenarios:
- Reset, then iSwitch=8'h00 held for 20 cycles -> oSwitch=8'h00, oChanged never 1.
- iSwitch 8'h00->8'h05 at edge 1, held -> oSwitch=8'h05 after edge 7; oChanged=1 for one cycle; mask=8'h05.
- iSwitch 8'h00->8'h01 for 2 cycles, then back to 8'h00 -> no commit; state returns to STABLE.
- iSwitch 8'h00->8'h01, then 8'h03 three cycles later, held -> a single commit of 8'h03 with mask=8'h03, 4 stable cycles after the 8'h03 reaches sync2.
- iRst pulsed while in SETTLE with counter=3 -> outputs 0 at once; after release with iSwitch=8'h80, commit at edge 7 with mask=8'h80.
- With SWITCH_DEBOUNCE_IRQ_EN defined: a commit makes oIrq=1 one cycle later; iIrqClr=1 then makes oIrq=0 on the next cycle; a simultaneous set and clear leaves oIrq=1.
